// File: rtl/dff_pipe.sv
// Tapped shift-register delay line: DEPTH stages of WIDTH-bit data plus a valid tag,
// with a run-time selectable output tap and a registered count of valid words.
module dff_pipe #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                CW        = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_valid,
    input  logic [CW-1:0]    tap_sel,
    output logic [WIDTH-1:0] q_out,
    output logic             q_valid,
    output logic [CW-1:0]    occupancy
);

    localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

    // Control: no handshake. Every rising edge with en=1 shifts one word in; flush=1 on
    // an edge clears all stages and wins over en; en=0 and flush=0 holds everything.
    logic [WIDTH-1:0] s [DEPTH];
    logic [DEPTH-1:0] v;
    logic [CW-1:0]    occ_q;
    logic [CW-1:0]    occ_d;
    logic [CW-1:0]    tap_idx;

    always_comb begin
        occ_d = occ_q;
        if (d_valid && !v[DEPTH-1]) begin
            occ_d = occ_q + CW'(1);
        end else if (!d_valid && v[DEPTH-1]) begin
            occ_d = occ_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                s[k] <= RESET_VAL;
            end
            v     <= '0;
            occ_q <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                s[k] <= RESET_VAL;
            end
            v     <= '0;
            occ_q <= '0;
        end else if (en) begin
            s[0] <= d_in;
            for (int k = 1; k < DEPTH; k++) begin
                s[k] <= s[k-1];
            end
            v     <= {v[DEPTH-2:0], d_valid};
            occ_q <= occ_d;
        end
    end

    // Out-of-range taps (0 or beyond DEPTH) read the last stage.
    always_comb begin
        tap_idx = DEPTH_CW - CW'(1);
        if (tap_sel != '0 && tap_sel <= DEPTH_CW) begin
            tap_idx = tap_sel - CW'(1);
        end
    end

    always_comb begin
        q_out   = s[0];
        q_valid = v[0];
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_idx == CW'(k)) begin
                q_out   = s[k];
                q_valid = v[k];
            end
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe (WIDTH=8, DEPTH=4, RESET_VAL=0) with hand-computed expectations.
module tb_dff_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d_in;
    logic             d_valid;
    logic [CW-1:0]    tap_sel;
    logic [WIDTH-1:0] q_out;
    logic             q_valid;
    logic [CW-1:0]    occupancy;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL('0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .d_in      (d_in),
        .d_valid   (d_valid),
        .tap_sel   (tap_sel),
        .q_out     (q_out),
        .q_valid   (q_valid),
        .occupancy (occupancy)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] data, input logic valid);
        d_in    = data;
        d_valid = valid;
        step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_tap(input string tag, input int tap,
                             input logic [WIDTH-1:0] exp_d, input logic exp_v);
        tap_sel = CW'(tap);
        #1;
        check({tag, "_q"}, 32'(q_out), 32'(exp_d));
        check({tag, "_v"}, 32'(q_valid), 32'(exp_v));
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        flush   = 1'b0;
        d_in    = '0;
        d_valid = 1'b0;
        tap_sel = CW'(4);
        #12;
        check("reset_q", 32'(q_out), 32'h00);
        check("reset_v", 32'(q_valid), 32'h0);
        check("reset_occ", 32'(occupancy), 32'h0);
        rst_n = 1'b1;

        // Fill four valid words with tap 4.
        en = 1'b1;
        push(8'h11, 1'b1);
        check("fill1_occ", 32'(occupancy), 32'd1);
        check("fill1_tap4_v", 32'(q_valid), 32'h0);
        push(8'h22, 1'b1);
        check("fill2_occ", 32'(occupancy), 32'd2);
        push(8'h33, 1'b1);
        check("fill3_occ", 32'(occupancy), 32'd3);
        push(8'h44, 1'b1);
        check("fill4_occ", 32'(occupancy), 32'd4);
        check_tap("fill4_tap4", 4, 8'h11, 1'b1);

        // Tap sweep with en=0; contents must hold.
        en = 1'b0;
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h11);
        for (int t = 1; t <= DEPTH; t++) begin
            check_tap($sformatf("sweep_tap%0d", t), t, exp_q.pop_front(), 1'b1);
        end
        push(8'h99, 1'b1);
        check_tap("hold_tap4", 4, 8'h11, 1'b1);
        check_tap("hold_tap1", 1, 8'h44, 1'b1);
        check("hold_occ", 32'(occupancy), 32'd4);

        // Out-of-range taps clamp to DEPTH.
        check_tap("clamp_tap0", 0, 8'h11, 1'b1);
        check_tap("clamp_tap7", 7, 8'h11, 1'b1);

        // Drain with invalid words: data still shifts.
        en = 1'b1;
        push(8'h55, 1'b0);
        check("drain1_occ", 32'(occupancy), 32'd3);
        check_tap("drain1_tap1", 1, 8'h55, 1'b0);
        check_tap("drain1_tap4", 4, 8'h22, 1'b1);
        push(8'h66, 1'b0);
        check("drain2_occ", 32'(occupancy), 32'd2);
        check_tap("drain2_tap3", 3, 8'h44, 1'b1);

        // Valid in while valid out: occupancy unchanged.
        push(8'hA1, 1'b1);
        check("swap1_occ", 32'(occupancy), 32'd2);
        push(8'hA2, 1'b1);
        check("swap2_occ", 32'(occupancy), 32'd2);
        check_tap("swap2_tap2", 2, 8'hA1, 1'b1);
        check_tap("swap2_tap3", 3, 8'h66, 1'b0);
        push(8'hA3, 1'b1);
        check("refill3_occ", 32'(occupancy), 32'd3);
        push(8'hA4, 1'b1);
        check("refill4_occ", 32'(occupancy), 32'd4);
        check_tap("refill4_tap4", 4, 8'hA1, 1'b1);

        // Flush together with en: flush wins, d_in lost.
        flush = 1'b1;
        push(8'hEE, 1'b1);
        flush = 1'b0;
        for (int t = 1; t <= DEPTH; t++) begin
            check_tap($sformatf("flush_tap%0d", t), t, 8'h00, 1'b0);
        end
        check("flush_occ", 32'(occupancy), 32'd0);

        // Invalid word into an empty pipe: occupancy must not wrap.
        push(8'h77, 1'b0);
        check("empty_occ", 32'(occupancy), 32'd0);
        check_tap("empty_tap1", 1, 8'h77, 1'b0);

        // Asynchronous reset mid-cycle with a partly filled pipe.
        push(8'hB1, 1'b1);
        push(8'hB2, 1'b1);
        check("partial_occ", 32'(occupancy), 32'd2);
        check_tap("partial_tap1", 1, 8'hB2, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_occ", 32'(occupancy), 32'd0);
        check("async_q", 32'(q_out), 32'h00);
        check("async_v", 32'(q_valid), 32'h0);
        tap_sel = CW'(2);
        #1;
        check("async_tap2_q", 32'(q_out), 32'h00);
        en    = 1'b0;
        rst_n = 1'b1;
        step();
        check_tap("post_rst_tap2", 2, 8'h00, 1'b0);
        check_tap("post_rst_tap3", 3, 8'h00, 1'b0);
        check("post_rst_occ", 32'(occupancy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage (legal 1..64).
REQ-002 Parameter DEPTH, default 4, number of register stages (legal 2..32).
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data stage on reset or flush.
REQ-004 The design SHALL derive CW = clog2(DEPTH)+1 as the width of tap_sel and occupancy.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  advance pipeline by one stage this cycle.
REQ-008 flush  input  1  synchronous clear of all stages.
REQ-009 d_in  input  WIDTH  data captured into stage 0.
REQ-010 d_valid  input  1  valid tag captured with d_in.
REQ-011 tap_sel  input  CW  selected delay in cycles (1..DEPTH).
REQ-012 q_out  output  WIDTH  data of the selected stage.
REQ-013 q_valid  output  1  valid tag of the selected stage.
REQ-014 occupancy  output  CW  count of valid tags held across all stages.

Function
REQ-015 The design SHALL hold DEPTH data registers s[0..DEPTH-1] and DEPTH valid bits v[0..DEPTH-1].
REQ-016 With en=1 and flush=0, on each rising edge: s[0]<=d_in, v[0]<=d_valid; s[k]<=s[k-1], v[k]<=v[k-1] for k=1..DEPTH-1; s[DEPTH-1] and v[DEPTH-1] contents are discarded.
REQ-017 With en=0 and flush=0, all s and v SHALL hold; d_in and d_valid are ignored.
REQ-018 flush=1 SHALL take priority over en: on the edge, every s[k]<=RESET_VAL and every v[k]<=0.
REQ-019 Effective tap t = tap_sel when 1<=tap_sel<=DEPTH; tap_sel=0 or tap_sel>DEPTH SHALL clamp to t=DEPTH.
REQ-020 q_out=s[t-1] and q_valid=v[t-1], combinational from the registers and tap_sel, with no register on the output path.
REQ-021 Latency: with en held 1, a word presented on d_in at edge n SHALL appear on q_out after edge n+t-1, i.e. during cycle n+t-1 through n+t (t edges after capture counting the capture edge).
REQ-022 A change to tap_sel SHALL take effect in the same cycle, without disturbing stored contents.
REQ-023 occupancy SHALL be a registered popcount of v[], updated on the same edge as v[]; range 0..DEPTH, never wraps.
REQ-024 occupancy SHALL increment only when d_valid=1 and v[DEPTH-1]=0 on an enabled edge, decrement only when d_valid=0 and v[DEPTH-1]=1, and otherwise stay unchanged; flush sets it to 0.
REQ-025 Invalid words (d_valid=0) SHALL still shift data; q_out then shows the carried data with q_valid=0.
REQ-026 Simultaneous en and flush SHALL behave as flush alone; d_in on that edge is lost.

Reset
REQ-027 rst_n=0 SHALL asynchronously force all s[k]=RESET_VAL, all v[k]=0 and occupancy=0, independent of clk.
REQ-028 While rst_n=0, q_out=RESET_VAL and q_valid=0 for any tap_sel.
REQ-029 Deassertion of rst_n SHALL be synchronised externally; the first edge with rst_n=1 behaves per REQ-016..018.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight words; no word captured before reset appears afterwards.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=0)
REQ-031 Reset then en=1, d_valid=1, d_in=0x11,0x22,0x33,0x44 on four edges, tap_sel=4 -> q_out=0x11 with q_valid=1 after the fourth edge; occupancy=4.
REQ-032 Same fill, then tap_sel swept 1,2,3,4 with en=0 -> q_out=0x44,0x33,0x22,0x11, with contents unchanged.
REQ-033 Full pipe, en=1, d_valid=0 for 2 edges -> occupancy 4->3->2; q_valid=0 at tap 1 after the first edge.
REQ-034 Full pipe, en=1 and flush=1 on the same edge -> all q_valid=0, q_out=0x00, occupancy=0.
REQ-035 tap_sel=0 and tap_sel=7 -> same q_out as tap_sel=4.
REQ-036 rst_n pulsed low between clock edges with a partly filled pipe -> outputs clear immediately, before the next edge.
